// File: rtl/cdc_multi_event_rx_pkg.sv
// Shared constants and helpers for the multi-channel CDC event receiver.
package cdc_evt_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 4;

    // A single channel still needs a one-bit channel index port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdc_multi_event_rx_if.sv
// Event handshake bundle: the receiver presents (valid, ch), the consumer answers with ready.
interface cdc_multi_event_rx_if
    import cdc_evt_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
);

    localparam int CH_W = clog2_min1(NUM_CH);

    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );

endinterface

// File: rtl/cdc_multi_event_rx_sync_bit_chain.sv
// One-bit multi-flop synchroniser for a level crossing into the clk domain.
module sync_bit_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_multi_event_rx.sv
// Multi-channel toggle-event receiver with saturating pending counters and round-robin serving.
// Optional sticky overflow status is built only when CDC_EVT_OVF_STATUS_EN is defined.
module cdc_multi_event_rx
    import cdc_evt_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   async_toggle,
    cdc_multi_event_rx_if.master evt,
    output logic [NUM_CH-1:0]   evt_ovf,
    input  logic [NUM_CH-1:0]   ovf_clr
);

    localparam int                CH_W    = clog2_min1(NUM_CH);
    localparam int                ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_INIT = ARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] sync_last;
    logic [NUM_CH-1:0] hist;
    logic [NUM_CH-1:0] det;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] dec;
    logic [NUM_CH-1:0] nonzero;
    logic [CNT_W-1:0]  cnt [NUM_CH];

    logic [ARM_W-1:0]  arm_cnt;
    logic              armed;

    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   ch;
    logic              valid;
    logic              hs;
    logic              hold;
    logic [CH_W-1:0]   hold_ch;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        sync_bit_chain #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (async_toggle[g]),
            .q   (sync_last[g])
        );
    end

    // History keeps tracking during arming so levels present at reset release are absorbed silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist    <= '0;
            arm_cnt <= ARM_INIT;
        end else begin
            hist <= sync_last;
            if (arm_cnt != '0) begin
                arm_cnt <= arm_cnt - 1'b1;
            end
        end
    end

    assign armed = (arm_cnt == '0);
    assign det   = sync_last ^ hist;
    assign inc   = det & {NUM_CH{armed}};
    assign hs    = valid && evt.evt_ready;

    always_comb begin
        dec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            dec[i] = hs && (ch == CH_W'(i));
        end
    end

    // Simultaneous increment and decrement cancel, so a full counter is not an overflow then.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case ({inc[i], dec[i]})
                    2'b10: begin
                        if (cnt[i] != CNT_MAX) begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    2'b01: cnt[i] <= cnt[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        nonzero = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nonzero[i] = (cnt[i] != '0);
        end
    end

    // Two passes give the wrapped search order ptr..NUM_CH-1 then 0..ptr-1.
    always_comb begin
        logic found;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && nonzero[i] && (CH_W'(i) >= ptr)) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && nonzero[i] && (CH_W'(i) < ptr)) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end
    end

    assign valid = |nonzero;
    assign ch    = hold ? hold_ch : sel;

    // A stalled offer is latched; only a handshake can drain that channel, so it stays valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            hold    <= 1'b0;
            hold_ch <= '0;
        end else begin
            hold    <= valid && !evt.evt_ready;
            hold_ch <= ch;
            if (hs) begin
                ptr <= (ch == LAST_CH) ? '0 : ch + 1'b1;
            end
        end
    end

    assign evt.evt_valid = valid;
    assign evt.evt_ch    = ch;

`ifdef CDC_EVT_OVF_STATUS_EN
    logic [NUM_CH-1:0] sat;
    logic [NUM_CH-1:0] ovf_q;

    always_comb begin
        sat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sat[i] = inc[i] && !dec[i] && (cnt[i] == CNT_MAX);
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~ovf_clr) | sat;
        end
    end

    assign evt_ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ^ovf_clr;
    assign evt_ovf        = '0;
`endif

endmodule

// File: tb/tb_cdc_multi_event_rx.sv
// Directed, table-driven bench for cdc_multi_event_rx (default parameters).
module tb_cdc_multi_event_rx;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] async_toggle;
    logic [NUM_CH-1:0] evt_ovf;
    logic [NUM_CH-1:0] ovf_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdc_multi_event_rx_if #(.NUM_CH(NUM_CH)) evt_bus ();

    cdc_multi_event_rx #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (2),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .async_toggle (async_toggle),
        .evt          (evt_bus.master),
        .evt_ovf      (evt_ovf),
        .ovf_clr      (ovf_clr)
    );

    typedef struct {
        logic       rst;
        logic [3:0] tog;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t vecs[$];

    task automatic applyStimulus(input logic r, input logic [3:0] t, input logic rdy, input logic [3:0] clr);
        rst               = r;
        async_toggle      = t;
        evt_bus.evt_ready = rdy;
        ovf_clr           = clr;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s #%0d actual=%0h required=%0h", name, id, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic [3:0] t, input logic rdy, input logic v, input logic [1:0] c);
        vec_t e;
        e.rst       = r;
        e.tog       = t;
        e.rdy       = rdy;
        e.exp_valid = v;
        e.exp_ch    = c;
        vecs.push_back(e);
    endtask

    logic [3:0] exp_ovf;
    int         n_hs;
    logic       done;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Single event on ch2 with ready high: visible 3 edges after the change, for one cycle.
        addVec(0, 4'b1110, 1, 0, 0);
        addVec(0, 4'b1110, 1, 0, 0);
        addVec(0, 4'b1110, 1, 1, 2);
        addVec(0, 4'b1110, 1, 0, 0);
        addVec(0, 4'b1110, 1, 0, 0);
        // Reset to bring the pointer back to 0, then wait out arming.
        addVec(1, 4'b1110, 1, 0, 0);
        for (int k = 0; k < 5; k++) addVec(0, 4'b1110, 1, 0, 0);
        // Channels 0,1,3 together: served 0,1,3 back to back.
        addVec(0, 4'b0101, 1, 0, 0);
        addVec(0, 4'b0101, 1, 0, 0);
        addVec(0, 4'b0101, 1, 1, 0);
        addVec(0, 4'b0101, 1, 1, 1);
        addVec(0, 4'b0101, 1, 1, 3);
        addVec(0, 4'b0101, 1, 0, 0);
        // Channels 1 and 3 together: ch1 first proves the pointer wrapped to 0.
        addVec(0, 4'b1111, 1, 0, 0);
        addVec(0, 4'b1111, 1, 0, 0);
        addVec(0, 4'b1111, 1, 1, 1);
        addVec(0, 4'b1111, 1, 1, 3);
        addVec(0, 4'b1111, 1, 0, 0);
        // Backpressure: ch3 pending, ch0 arrives later, ch3 must stay presented.
        addVec(0, 4'b0111, 0, 0, 0);
        addVec(0, 4'b0111, 0, 0, 0);
        addVec(0, 4'b0111, 0, 1, 3);
        addVec(0, 4'b0110, 0, 1, 3);
        addVec(0, 4'b0110, 0, 1, 3);
        addVec(0, 4'b0110, 0, 1, 3);
        addVec(0, 4'b0110, 0, 1, 3);
        addVec(0, 4'b0110, 1, 1, 0);
        addVec(0, 4'b0110, 1, 0, 0);

        applyStimulus(1, 4'b1010, 0, 4'b0000);
        step(2);
        checkOutput("reset_valid", 0, evt_bus.evt_valid, 0);
        checkOutput("reset_ch", 0, evt_bus.evt_ch, 0);
        checkOutput("reset_ovf", 0, evt_ovf, 0);

        applyStimulus(0, 4'b1010, 0, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            step(1);
            checkOutput("arm_no_spurious", k, evt_bus.evt_valid, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].tog, vecs[i].rdy, 4'b0000);
            step(1);
            checkOutput("vec_valid", i, evt_bus.evt_valid, 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid || vecs[i].rst) begin
                checkOutput("vec_ch", i, evt_bus.evt_ch, 32'(vecs[i].exp_ch));
            end
        end

        // Saturation: 20 changes on ch1 under backpressure leave 15 pending.
        applyStimulus(0, 4'b0110, 0, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            async_toggle[1] = ~async_toggle[1];
            step(2);
        end
        step(4);
        checkOutput("sat_valid", 0, evt_bus.evt_valid, 1);
        checkOutput("sat_ch", 0, evt_bus.evt_ch, 1);
`ifdef CDC_EVT_OVF_STATUS_EN
        exp_ovf = 4'b0010;
`else
        exp_ovf = 4'b0000;
`endif
        checkOutput("sat_ovf", 0, evt_ovf, 32'(exp_ovf));
        ovf_clr = 4'b0010;
        step(1);
        ovf_clr = 4'b0000;
        checkOutput("ovf_clear", 0, evt_ovf, 0);

        evt_bus.evt_ready = 1'b1;
        n_hs = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (!evt_bus.evt_valid) begin
                done = 1'b1;
            end else begin
                checkOutput("drain_ch", n_hs, evt_bus.evt_ch, 1);
                n_hs++;
                step(1);
            end
        end
        checkOutput("drain_count", 0, n_hs, 15);

        // Reset with pending events on ch0 and ch2 (pointer is at 2 now).
        applyStimulus(0, 4'b0011, 0, 4'b0000);
        step(4);
        checkOutput("pre_rst_valid", 0, evt_bus.evt_valid, 1);
        checkOutput("pre_rst_ch", 0, evt_bus.evt_ch, 2);
        applyStimulus(1, 4'b0011, 0, 4'b0000);
        step(1);
        checkOutput("mid_rst_valid", 0, evt_bus.evt_valid, 0);
        checkOutput("mid_rst_ch", 0, evt_bus.evt_ch, 0);
        applyStimulus(0, 4'b0011, 1, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            step(1);
            checkOutput("post_rst_quiet", k, evt_bus.evt_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
